uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter_pkg.sv | 20 ++
 rtl/uart_transmitter.sv | 147 ++++++++++++++
 tb/tb_uart_transmitter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package uart_transmitter_pkg;

    // State encoding shared by the receiver and transmitter FSMs.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART serialiser: start bit, DATA_WIDTH bits LSB-first, STOP_BITS stop bits; one-entry holding register.
// Latency: byte accepted at edge N drives the start bit from edge N+1; each bit lasts OVERSAMPLE baudTicks.
// Backpressure: ready = holding register empty; txStart while ready=0 is dropped (overrun).
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int STOP_BITS  = 1             // 1 or 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baudTick,
    input  logic                  txStart,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic                  ready,
    output logic                  busy,
    output logic                  tx,
    output logic                  tx_done
);

    localparam int TICK_W = cnt_width(OVERSAMPLE);
    localparam int BIT_W  = cnt_width(DATA_WIDTH);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    // The stop counter is one bit wide: its last value is 1 only for two stop bits.
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    logic [1:0]            state_q,    state_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0] shifter_q,  shifter_d;
    logic [DATA_WIDTH-1:0] hold_reg_q, hold_reg_d;
    logic                  hold_vld_q, hold_vld_d;
    logic                  tx_q,       tx_d;
    logic                  bit_end;

    assign ready = ~hold_vld_q;
    assign busy  = (state_q != ST_IDLE);
    assign tx    = tx_q;

    // Next-state logic: holding-register accept, FSM sequencing and the registered line value.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shifter_d  = shifter_q;
        hold_reg_d = hold_reg_q;
        hold_vld_d = hold_vld_q;
        tx_done    = 1'b0;

        // Last tick of the current bit period.
        bit_end = baudTick && (tick_cnt_q == TICK_LAST);

        // Accept only into an empty register; drains below require it full, so they never overlap.
        if (txStart && ready) begin
            hold_reg_d = dataIn;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_vld_q) begin
                    shifter_d  = hold_reg_q;
                    hold_vld_d = 1'b0;
                    tick_cnt_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_DATA;
                end else if (baudTick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    shifter_d  = shifter_q >> 1;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        stop_cnt_d = 1'b0;
                        state_d    = ST_STOP;
                    end
                end else if (baudTick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: begin // ST_STOP
                if (bit_end) begin
                    tick_cnt_d = '0;
                    stop_cnt_d = stop_cnt_q + 1'b1;
                    if (stop_cnt_q == STOP_LAST) begin
                        tx_done = 1'b1;
                        // A queued byte starts on this same edge: no idle gap between frames.
                        if (hold_vld_q) begin
                            shifter_d  = hold_reg_q;
                            hold_vld_d = 1'b0;
                            state_d    = ST_START;
                        end else begin
                            state_d    = ST_IDLE;
                        end
                    end
                end else if (baudTick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
        endcase

        // Line value follows the next state so tx and state change on the same edge.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shifter_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers with synchronous reset; reset drops any queued byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shifter_q  <= '0;
            hold_reg_q <= '0;
            hold_vld_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shifter_q  <= shifter_d;
            hold_reg_q <= hold_reg_d;
            hold_vld_q <= hold_vld_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: directed bytes into two instances (1 and 2 stop bits).
// A per-instance line monitor reconstructs every frame tick by tick and checks it against a queue of expected bytes.
// Stimulus only pushes expected bytes; frame and tx_done timing checks live in the monitor.
`timescale 1ns/1ps
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       baudTick;
    logic       txStart, txStart2;
    logic [7:0] dataIn, dataIn2;
    logic       ready, busy, tx, tx_done;
    logic       ready2, busy2, tx2, tx_done2;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  exp0[$];
    logic [7:0]  exp1[$];
    int          frames_done[2];
    bit          in_frame[2];
    bit          unexpected[2];
    int          nticks[2];
    logic [10:0] exp_bits[2];
    logic [7:0]  cur_byte[2];
    int          line_err[2];
    int          done_err[2];
    int          gap[2];
    int          last_gap[2];
    int          stray[2];
    int          bcnt = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.DATA_WIDTH(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .baudTick(baudTick), .txStart(txStart), .dataIn(dataIn),
        .ready(ready), .busy(busy), .tx(tx), .tx_done(tx_done)
    );

    uart_transmitter #(.DATA_WIDTH(8), .OVERSAMPLE(16), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .baudTick(baudTick), .txStart(txStart2), .dataIn(dataIn2),
        .ready(ready2), .busy(busy2), .tx(tx2), .tx_done(tx_done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // One monitor step per clk, sampled on the falling edge.
    task automatic mon_step(input int id, input logic txv, input logic done, input logic tick);
        int         total;
        logic       exp_done;
        logic [7:0] b;
        total = (1 + 8 + ((id == 0) ? 1 : 2)) * 16;
        if (rst === 1'b1) begin
            in_frame[id] = 1'b0;
            return;
        end
        if (!in_frame[id]) begin
            if (done === 1'b1) stray[id]++;
            if (txv !== 1'b0) begin
                gap[id]++;
                return;
            end
            last_gap[id]   = gap[id];
            gap[id]        = 0;
            unexpected[id] = 1'b0;
            b              = 8'h00;
            if (id == 0 && exp0.size() > 0) b = exp0.pop_front();
            else if (id == 1 && exp1.size() > 0) b = exp1.pop_front();
            else begin
                unexpected[id] = 1'b1;
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_frame dut%0d: a frame started, expected none", id);
            end
            cur_byte[id] = b;
            exp_bits[id] = {2'b11, b, 1'b0};
            in_frame[id] = 1'b1;
            nticks[id]   = 0;
            line_err[id] = 0;
            done_err[id] = 0;
        end
        if (txv !== exp_bits[id][nticks[id] / 16]) line_err[id]++;
        if (tick === 1'b1) nticks[id]++;
        exp_done = (tick === 1'b1) && (nticks[id] == total);
        if (done !== exp_done) done_err[id]++;
        if (exp_done) begin
            if (!unexpected[id]) begin
                chk($sformatf("frame_line dut%0d byte %02h (bad cycles)", id, cur_byte[id]), line_err[id], 0);
                chk($sformatf("tx_done_timing dut%0d byte %02h (bad cycles)", id, cur_byte[id]), done_err[id], 0);
            end
            in_frame[id] = 1'b0;
            frames_done[id]++;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, tx, tx_done, baudTick);
        mon_step(1, tx2, tx_done2, baudTick);
    end

    // baudTick: one clk wide, every 4th cycle.
    initial begin
        baudTick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            baudTick = (bcnt == 3);
            bcnt     = (bcnt + 1) % 4;
        end
    end

    task automatic send(input int id, input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        while (((id == 0) ? ready : ready2) !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout dut%0d: ready stayed low, expected high", id);
        end
        if (id == 0) begin
            exp0.push_back(b);
            txStart = 1'b1;
            dataIn  = b;
        end else begin
            exp1.push_back(b);
            txStart2 = 1'b1;
            dataIn2  = b;
        end
        @(posedge clk);
        #1;
        txStart  = 1'b0;
        txStart2 = 1'b0;
    endtask

    task automatic wait_frames(input int id, input int target);
        int k = 0;
        while (frames_done[id] < target && k < 3000) begin
            @(posedge clk);
            k++;
        end
        chk($sformatf("frame_count dut%0d", id), frames_done[id], target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int rdy_bad;

        // Reset with txStart held high: nothing may be queued.
        rst      = 1'b1;
        txStart  = 1'b1;
        dataIn   = 8'h55;
        txStart2 = 1'b0;
        dataIn2  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_tx_dut2", tx2, 1);
        rst     = 1'b0;
        txStart = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_tx", tx, 1);

        // Single byte 0xA5 with accept-to-start latency.
        send(0, 8'hA5);
        chk("accept_edge_tx", tx, 1);
        chk("accept_edge_ready", ready, 0);
        @(posedge clk);
        #1;
        chk("start_edge_tx", tx, 0);
        chk("start_edge_busy", busy, 1);
        chk("start_edge_ready", ready, 1);
        wait_frames(0, 1);

        // Back-to-back: 0x00 then 0xFF queued during data bit 2.
        send(0, 8'h00);
        repeat (56 * 4) @(posedge clk);
        send(0, 8'hFF);
        rdy_bad = 0;
        k       = 0;
        do begin
            @(negedge clk);
            k++;
            if (ready !== 1'b0) rdy_bad++;
        end while (tx_done !== 1'b1 && k < 2000);
        chk("b2b_first_done_seen", tx_done, 1);
        chk("b2b_ready_low_cycles", rdy_bad, 0);
        @(posedge clk);
        #1;
        chk("b2b_ready_after_drain", ready, 1);
        chk("b2b_start_tx", tx, 0);
        wait_frames(0, 3);
        chk("b2b_idle_gap", last_gap[0], 0);

        // Overrun: 0x99 offered while 0x3C occupies the holding register.
        send(0, 8'h11);
        send(0, 8'h3C);
        @(negedge clk);
        chk("overrun_ready_low", ready, 0);
        txStart = 1'b1;
        dataIn  = 8'h99;
        @(posedge clk);
        #1;
        txStart = 1'b0;
        wait_frames(0, 5);

        // Two stop bits: 0x81, done on tick 176.
        send(1, 8'h81);
        wait_frames(1, 1);

        // Reset mid-frame during data bit 3 of 0xF0 with 0x12 queued.
        send(0, 8'hF0);
        send(0, 8'h12);
        repeat (68 * 4) @(posedge clk);
        #1;
        chk("midframe_tx_low", tx, 0);
        chk("midframe_ready_full", ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_tx", tx, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_ready", ready, 1);
        exp0.delete();
        repeat (800) @(posedge clk);
        send(0, 8'h5A);
        wait_frames(0, 6);

        repeat (50) @(posedge clk);
        #1;
        chk("stray_tx_done_dut0", stray[0], 0);
        chk("stray_tx_done_dut2", stray[1], 0);
        chk("pending_expected_dut0", exp0.size(), 0);
        chk("pending_expected_dut2", exp1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
